// File: rtl/fpu_to_int.sv
// fpu_to_int: converts a packed 32-bit float (1 sign, 6-bit exponent with
// bias 31, 25-bit fraction with hidden 1) to a 32-bit two's-complement
// integer, truncating toward zero. The magnitude is aligned by an iterative
// shifter that moves one bit per cycle.
//
// Ports:
//   clock100KHz  in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   conversion request, sampled only while idle
//   op_in        in   packed float {sign, exp[5:0], frac[24:0]}
//   busy         out  high while a conversion is in progress (state != IDLE)
//   done         out  one-cycle pulse when data_out/status_out are updated
//   data_out     out  signed integer result, held until the next done
//   status_out   out  0 EXACT, 1 INEXACT, 2 OVERFLOW, 3 UNDERFLOW
module fpu_to_int (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned EXP_W  = 6;
    localparam int unsigned FRAC_W = 25;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned STAT_W = 4;

    localparam logic [STAT_W-1:0] ST_EXACT     = 4'd0;
    localparam logic [STAT_W-1:0] ST_INEXACT   = 4'd1;
    localparam logic [STAT_W-1:0] ST_OVERFLOW  = 4'd2;
    localparam logic [STAT_W-1:0] ST_UNDERFLOW = 4'd3;

    // Exponent fields: bias (E=0), the unshifted point (E=25) and E=31.
    localparam logic [EXP_W-1:0] EXP_BIAS  = 6'd31;
    localparam logic [EXP_W-1:0] EXP_ALIGN = 6'd56;
    localparam logic [EXP_W-1:0] EXP_SAT   = 6'd62;

    localparam logic [DATA_W-1:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SHIFT  = 3'd2,
        S_NEGATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // Captured operand.
    logic              sign_q;
    logic [EXP_W-1:0]  exp_q;
    logic [FRAC_W-1:0] frac_q;

    // Shifter datapath.
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              left_q;
    logic              sticky_q;

    logic [DATA_W-1:0] acc_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              left_d;
    logic              sticky_d;

    logic [DATA_W-1:0] result_c;
    logic [STAT_W-1:0] status_c;

    // Operand classification, only meaningful in CHECK.
    logic             is_zero_c;
    logic             is_under_c;
    logic             is_min_c;
    logic             is_over_c;
    logic             is_special_c;
    logic             is_left_c;
    logic [CNT_W-1:0] shift_n_c;

    assign is_zero_c    = (exp_q == '0) && (frac_q == '0);
    assign is_under_c   = (exp_q < EXP_BIAS);
    assign is_min_c     = (exp_q == EXP_SAT) && sign_q && (frac_q == '0);
    assign is_over_c    = (exp_q >= EXP_SAT);
    assign is_special_c = is_zero_c || is_under_c || is_over_c;
    assign is_left_c    = (exp_q > EXP_ALIGN);
    // Normal path has E in 0..30, so N = |E-25| fits in 5 bits (max 25).
    assign shift_n_c    = is_left_c ? CNT_W'(exp_q - EXP_ALIGN)
                                    : CNT_W'(EXP_ALIGN - exp_q);

    // State register.
    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (is_special_c) begin
                    next_state = S_DONE;
                end else if (shift_n_c == '0) begin
                    next_state = S_NEGATE;
                end else begin
                    next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // The last shift decrements the count to zero.
                if (cnt_q == CNT_W'(1)) begin
                    next_state = S_NEGATE;
                end
            end
            S_NEGATE: next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        sticky_d = sticky_q;
        result_c = '0;
        status_c = ST_EXACT;
        case (state)
            S_CHECK: begin
                acc_d    = DATA_W'({1'b1, frac_q});
                cnt_d    = shift_n_c;
                left_d   = is_left_c;
                sticky_d = 1'b0;
                if (is_zero_c) begin
                    result_c = '0;
                    status_c = ST_EXACT;
                end else if (is_under_c) begin
                    result_c = '0;
                    status_c = ST_UNDERFLOW;
                end else if (is_min_c) begin
                    result_c = INT_MIN;
                    status_c = ST_EXACT;
                end else if (is_over_c) begin
                    result_c = sign_q ? INT_MIN : INT_MAX;
                    status_c = ST_OVERFLOW;
                end
            end
            S_SHIFT: begin
                if (left_q) begin
                    acc_d = acc_q << 1;
                end else begin
                    acc_d    = acc_q >> 1;
                    sticky_d = sticky_q | acc_q[0];
                end
                cnt_d = cnt_q - CNT_W'(1);
            end
            S_NEGATE: begin
                // Magnitude is already truncated, so negating rounds toward zero.
                result_c = sign_q ? (~acc_q + DATA_W'(1)) : acc_q;
                status_c = sticky_q ? ST_INEXACT : ST_EXACT;
            end
            default: begin
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            sign_q     <= 1'b0;
            exp_q      <= '0;
            frac_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            left_q     <= 1'b0;
            sticky_q   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
            status_out <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                sign_q <= op_in[31];
                exp_q  <= op_in[30:25];
                frac_q <= op_in[24:0];
            end
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            sticky_q <= sticky_d;
            busy     <= (next_state != S_IDLE);
            done     <= (next_state == S_DONE);
            if (next_state == S_DONE) begin
                data_out   <= result_c;
                status_out <= status_c;
            end
        end
    end

endmodule

// File: doc/fpu_to_int.md
# fpu_to_int

Sequential converter from the team's 32-bit floating-point format (1 sign, 6-bit exponent with bias 31, 25-bit fraction with hidden 1) to a 32-bit two's-complement integer, truncating toward zero. It is the unpacking counterpart of the FPU adder. It sits on the FPU result path and turns packed results back into integers for display and checking logic. It uses an iterative one-bit-per-cycle shifter and a start/done handshake, and reports status with the same 4-bit codes as the FPU.

## Interface
Parameters: none.
- clock100KHz  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op_in  in  32  packed float: [31] sign, [30:25] exponent, [24:0] fraction
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse; data_out and status_out are valid from this cycle on
- data_out  out  32  signed integer result, held until the next done
- status_out  out  4  status code: 0 EXACT, 1 INEXACT, 2 OVERFLOW, 3 UNDERFLOW

## Operation
- Value = (-1)^s × 1.f × 2^E, where E = exp − 31, giving E in −31..32.
- The datapath uses a 26-bit mantissa m = {1, f}.
- States: IDLE, CHECK, SHIFT, NEGATE, DONE.
- IDLE: when start=1, capture op_in and go to CHECK. In every other state start is ignored; there is no queuing.
- CHECK classifies the captured operand:
  - exp=0 and f=0: result 0, EXACT, go to DONE. Applies to both signs; −0 gives 0.
  - Otherwise E<0: result 0, UNDERFLOW, go to DONE.
  - E=31, s=1, f=0: result 0x80000000, EXACT, go to DONE.
  - E≥31 in any other case: saturate to 0x7FFFFFFF (s=0) or 0x80000000 (s=1), OVERFLOW, go to DONE.
  - 0≤E≤30: load accumulator acc=m, shift count N=|E−25|, direction (right if E<25, left if E>25), clear sticky. Go to SHIFT if N>0, else go to NEGATE.
- SHIFT: one bit per cycle and decrement N. On a right shift, OR the bit shifted out into sticky. When N reaches 0, go to NEGATE.
  - The accumulator is 32 bits wide. The maximum left shift is 5, and m<<5 is below 2^31, so no overflow is possible in this path.
- NEGATE: result = s ? −acc : acc. Status is INEXACT if sticky=1, else EXACT. Go to DONE.
- DONE: data_out and status_out are registered on entry and done=1 for this cycle. Go to IDLE on the next edge.
- Truncation is applied to the magnitude before negation, so the result always rounds toward zero.

## Timing
- Reset (any state, mid-conversion included): state IDLE, busy=0, done=0, data_out=0, status_out=0. Any in-flight conversion is discarded.
- Cycle numbering: start is high in cycle 0 and sampled at the end of cycle 0.
  - Cycle 1 is CHECK.
  - Special cases (zero, underflow, overflow, −2^31): DONE and done=1 in cycle 2.
  - Normal path: SHIFT occupies cycles 2..N+1, NEGATE is cycle N+2, and done=1 in cycle N+3.
  - Latency range is 3 (N=0) to 28 (N=25, E=0) cycles.
- busy=1 from cycle 1 through the DONE cycle inclusive. The earliest next start is accepted in the cycle after done.
- A start held high continuously begins a new conversion in the first IDLE cycle.
- op_in may change after the start cycle; it is captured in that cycle.
- done never lasts more than one cycle. data_out and status_out change only on entry to DONE or on reset.

## Test plan
- Reset mid-SHIFT (start with 0x3E000000, assert reset at cycle 5): next cycle busy=0, done=0, data_out=0, status_out=0. A start afterwards converts normally.
- 0x3E000000 (1.0): data_out=1, status 0, done in cycle 28. 0x40800000 (2.5): data_out=2, status 1 (INEXACT), done in cycle 27. 0xC0800000: data_out=0xFFFFFFFE, status 1.
- 0x70000000 (2^25): data_out=0x02000000, status 0, done in cycle 3. 0xF0000000: data_out=0xFE000000.
- 0xFC000000 (−2^31): data_out=0x80000000, status 0, done in cycle 2. 0x7C000000: data_out=0x7FFFFFFF, status 2. 0xFE000000: data_out=0x80000000, status 2.
- 0x3C000000 (0.5): data_out=0, status 3, done in cycle 2. 0x80000000 (−0): data_out=0, status 0.
- Pulse start again while busy: the pulse is ignored and only one done occurs. Back-to-back starts (start held high): the second conversion begins in the cycle after done, and data_out holds the first result until the second done.
